// File: rtl/router_pkg.sv
// Shared defaults and width helper for the sync-router block and its per-channel timers.
package router_pkg;

  localparam int unsigned NUM_CH_DEF  = 3;
  localparam int unsigned TIMEOUT_DEF = 30;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// One channel's stall watchdog: counts consecutive stall cycles, pulses soft reset
// when the limit is hit and records the event in a sticky flag.
module router_sync_timer
  import router_pkg::*;
#(
  parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned CNT_W   = width_of(TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_stall,
  input  logic i_flag_clr,
  output logic o_soft_reset,
  output logic o_timeout_flag
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_flag;
  logic             w_fire;

  assign w_fire = i_stall && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_pulse <= w_fire;
      if (!i_stall || w_fire) r_cnt <= '0;
      else                    r_cnt <= r_cnt + 1'b1;
      // A new timeout beats a clear arriving on the same edge.
      if (w_fire)          r_flag <= 1'b1;
      else if (i_flag_clr) r_flag <= 1'b0;
    end
  end

  assign o_soft_reset   = r_pulse;
  assign o_timeout_flag = r_flag;

endmodule

// File: rtl/router_sync_param.sv
// Router synchroniser: latches the packet destination, steers FIFO write enables and
// full status to it, and runs an independent stall watchdog per output channel.
module router_sync_param
  import router_pkg::*;
#(
  parameter  int unsigned NUM_CH  = NUM_CH_DEF,
  parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned ADDR_W  = width_of(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] datain,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  input  logic              flag_clr,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [NUM_CH-1:0] timeout_flag
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] r_dest;
  logic              r_dest_vld;
  logic              r_addr_err;
  logic              w_addr_ok;
  logic [NUM_CH-1:0] w_stall;

  assign w_addr_ok = ({1'b0, datain} < LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dest     <= '0;
      r_dest_vld <= 1'b0;
      r_addr_err <= 1'b0;
    end else if (detect_add) begin
      if (w_addr_ok) begin
        r_dest     <= datain;
        r_dest_vld <= 1'b1;
        r_addr_err <= 1'b0;
      end else begin
        r_dest_vld <= 1'b0;
        r_addr_err <= 1'b1;
      end
    end
  end

  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (r_dest_vld && (r_dest == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign addr_err = r_addr_err;
  assign vld_out  = ~empty;
  assign w_stall  = vld_out & ~read_enb;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_sync_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clk            (clk),
      .reset          (reset),
      .i_stall        (w_stall[g]),
      .i_flag_clr     (flag_clr),
      .o_soft_reset   (soft_reset[g]),
      .o_timeout_flag (timeout_flag[g])
    );
  end

endmodule

// File: tb/tb_router_sync_param.sv
// Bench for router_sync_param: default 3-channel/30-cycle instance plus a 5-channel/4-cycle one.
module tb_router_sync_param;

  logic clk = 1'b0;
  logic reset;

  logic       detect_add, write_enb_reg, flag_clr;
  logic [1:0] datain;
  logic [2:0] read_enb, empty, full;
  logic [2:0] write_enb, vld_out, soft_reset, timeout_flag;
  logic       fifo_full, addr_err;

  logic       detect_add_b, write_enb_reg_b, flag_clr_b;
  logic [2:0] datain_b;
  logic [4:0] read_enb_b, empty_b, full_b;
  logic [4:0] write_enb_b, vld_out_b, soft_reset_b, timeout_flag_b;
  logic       fifo_full_b, addr_err_b;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 clk = ~clk;

  router_sync_param dut (
    .clk(clk), .reset(reset), .detect_add(detect_add), .datain(datain),
    .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
    .flag_clr(flag_clr), .write_enb(write_enb), .fifo_full(fifo_full), .vld_out(vld_out),
    .soft_reset(soft_reset), .addr_err(addr_err), .timeout_flag(timeout_flag)
  );

  router_sync_param #(.NUM_CH(5), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .detect_add(detect_add_b), .datain(datain_b),
    .write_enb_reg(write_enb_reg_b), .read_enb(read_enb_b), .empty(empty_b), .full(full_b),
    .flag_clr(flag_clr_b), .write_enb(write_enb_b), .fifo_full(fifo_full_b), .vld_out(vld_out_b),
    .soft_reset(soft_reset_b), .addr_err(addr_err_b), .timeout_flag(timeout_flag_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; detect_add = 1'b1; datain = 2'd1; write_enb_reg = 1'b1; full = '1; empty = '1;
    detect_add_b = 1'b1; datain_b = 3'd4; write_enb_reg_b = 1'b1; full_b = '1; empty_b = '1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); total++;
    if ({write_enb, fifo_full, addr_err, soft_reset, timeout_flag} !== e[10:0]) begin
      bad++; $display("FAIL reset_a got=%b exp=%b",
                      {write_enb, fifo_full, addr_err, soft_reset, timeout_flag}, e[10:0]);
    end
    e = exp_q.pop_front(); total++;
    if ({write_enb_b, fifo_full_b, addr_err_b, soft_reset_b, timeout_flag_b} !== e[16:0]) begin
      bad++; $display("FAIL reset_b got=%b exp=%b",
                      {write_enb_b, fifo_full_b, addr_err_b, soft_reset_b, timeout_flag_b}, e[16:0]);
    end
    reset = 1'b0; detect_add = 1'b0; detect_add_b = 1'b0; full = '0; full_b = '0;
    write_enb_reg_b = 1'b0;
  endtask

  task automatic test_route();
    write_enb_reg = 1'b1; detect_add = 1'b1; datain = 2'd1;
    exp_q.push_back(32'h0); #1;
    e = exp_q.pop_front(); total++;
    if (write_enb !== e[2:0]) begin bad++; $display("FAIL route_pre got=%b exp=%b", write_enb, e[2:0]); end
    tick(); detect_add = 1'b0;
    exp_q.push_back(32'b010); #1;
    e = exp_q.pop_front(); total++;
    if (write_enb !== e[2:0]) begin bad++; $display("FAIL route_ch1 got=%b exp=%b", write_enb, e[2:0]); end
    full = 3'b010; exp_q.push_back(32'h1); #1;
    e = exp_q.pop_front(); total++;
    if (fifo_full !== e[0]) begin bad++; $display("FAIL full_set got=%b exp=%b", fifo_full, e[0]); end
    full = 3'b101; exp_q.push_back(32'h0); #1;
    e = exp_q.pop_front(); total++;
    if (fifo_full !== e[0]) begin bad++; $display("FAIL full_other got=%b exp=%b", fifo_full, e[0]); end
    detect_add = 1'b1; datain = 2'd2; exp_q.push_back(32'b010); #1;
    e = exp_q.pop_front(); total++;
    if (write_enb !== e[2:0]) begin bad++; $display("FAIL route_old_dest got=%b exp=%b", write_enb, e[2:0]); end
    tick(); detect_add = 1'b0;
    exp_q.push_back(32'b100); #1;
    e = exp_q.pop_front(); total++;
    if (write_enb !== e[2:0]) begin bad++; $display("FAIL route_ch2 got=%b exp=%b", write_enb, e[2:0]); end
    write_enb_reg = 1'b0; exp_q.push_back(32'b000); #1;
    e = exp_q.pop_front(); total++;
    if (write_enb !== e[2:0]) begin bad++; $display("FAIL route_idle got=%b exp=%b", write_enb, e[2:0]); end
    empty = 3'b010; exp_q.push_back(32'b101); #1;
    e = exp_q.pop_front(); total++;
    if (vld_out !== e[2:0]) begin bad++; $display("FAIL vld_out got=%b exp=%b", vld_out, e[2:0]); end
    empty = '1; full = '0;
  endtask

  task automatic test_addr_err();
    detect_add = 1'b1; datain = 2'd3; write_enb_reg = 1'b1; full = '1;
    exp_q.push_back({27'b0, 3'b000, 1'b0, 1'b1});
    tick(); detect_add = 1'b0; #1;
    e = exp_q.pop_front(); total++;
    if ({write_enb, fifo_full, addr_err} !== e[4:0]) begin
      bad++; $display("FAIL addr_err_oor got=%b exp=%b", {write_enb, fifo_full, addr_err}, e[4:0]);
    end
    detect_add = 1'b1; datain = 2'd0;
    exp_q.push_back({27'b0, 3'b001, 1'b1, 1'b0});
    tick(); detect_add = 1'b0; #1;
    e = exp_q.pop_front(); total++;
    if ({write_enb, fifo_full, addr_err} !== e[4:0]) begin
      bad++; $display("FAIL addr_recover got=%b exp=%b", {write_enb, fifo_full, addr_err}, e[4:0]);
    end
    write_enb_reg = 1'b0; full = '0;
    detect_add_b = 1'b1; datain_b = 3'd4; write_enb_reg_b = 1'b1;
    exp_q.push_back({26'b0, 5'b10000, 1'b0});
    tick(); detect_add_b = 1'b0; #1;
    e = exp_q.pop_front(); total++;
    if ({write_enb_b, addr_err_b} !== e[5:0]) begin
      bad++; $display("FAIL b_top_ch got=%b exp=%b", {write_enb_b, addr_err_b}, e[5:0]);
    end
    detect_add_b = 1'b1; datain_b = 3'd5;
    exp_q.push_back({26'b0, 5'b00000, 1'b1});
    tick(); detect_add_b = 1'b0; #1;
    e = exp_q.pop_front(); total++;
    if ({write_enb_b, addr_err_b} !== e[5:0]) begin
      bad++; $display("FAIL b_oor got=%b exp=%b", {write_enb_b, addr_err_b}, e[5:0]);
    end
    write_enb_reg_b = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    empty = 3'b110; read_enb = '0;
    for (int k = 1; k <= 60; k++) begin
      exp_q.push_back({26'b0, (k >= 30) ? 3'b001 : 3'b000, (k % 30 == 0) ? 3'b001 : 3'b000});
      tick();
      e = exp_q.pop_front(); total++;
      if ({timeout_flag, soft_reset} !== e[5:0]) begin
        bad++; $display("FAIL stall_c%0d got=%b exp=%b", k, {timeout_flag, soft_reset}, e[5:0]);
      end
    end
    empty = '1; exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); total++;
    if (soft_reset !== e[2:0]) begin bad++; $display("FAIL stall_end got=%b exp=%b", soft_reset, e[2:0]); end
    flag_clr = 1'b1; exp_q.push_back(32'h0);
    tick(); flag_clr = 1'b0;
    e = exp_q.pop_front(); total++;
    if (timeout_flag !== e[2:0]) begin bad++; $display("FAIL flag_clr got=%b exp=%b", timeout_flag, e[2:0]); end
  endtask

  task automatic test_restart();
    do_reset();
    empty = 3'b110;
    for (int k = 1; k <= 59; k++) begin
      read_enb = (k == 30) ? 3'b001 : 3'b000;
      exp_q.push_back(32'h0);
      tick();
      e = exp_q.pop_front(); total++;
      if (soft_reset !== e[2:0]) begin bad++; $display("FAIL read_gap_c%0d got=%b exp=%b", k, soft_reset, e[2:0]); end
    end
    read_enb = '0; empty = '1;
    tick();
    empty = 3'b110;
    for (int k = 1; k <= 19; k++) tick();
    reset = 1'b1; exp_q.push_back(32'h0);
    tick(); reset = 1'b0;
    e = exp_q.pop_front(); total++;
    if (soft_reset !== e[2:0]) begin bad++; $display("FAIL mid_reset got=%b exp=%b", soft_reset, e[2:0]); end
    for (int k = 1; k <= 30; k++) begin
      exp_q.push_back((k == 30) ? 32'b001 : 32'b000);
      tick();
      e = exp_q.pop_front(); total++;
      if (soft_reset !== e[2:0]) begin bad++; $display("FAIL post_reset_c%0d got=%b exp=%b", k, soft_reset, e[2:0]); end
    end
    empty = '1;
    tick();
  endtask

  task automatic test_multi();
    do_reset();
    empty_b = 5'b01110; read_enb_b = '0;
    for (int k = 1; k <= 4; k++) begin
      flag_clr_b = (k == 4);
      exp_q.push_back((k == 4) ? {22'b0, 5'b10001, 5'b10001} : 32'h0);
      tick();
      e = exp_q.pop_front(); total++;
      if ({timeout_flag_b, soft_reset_b} !== e[9:0]) begin
        bad++; $display("FAIL multi_c%0d got=%b exp=%b", k, {timeout_flag_b, soft_reset_b}, e[9:0]);
      end
    end
    empty_b = '1; flag_clr_b = 1'b0;
    exp_q.push_back({22'b0, 5'b10001, 5'b00000});
    tick();
    e = exp_q.pop_front(); total++;
    if ({timeout_flag_b, soft_reset_b} !== e[9:0]) begin
      bad++; $display("FAIL multi_hold got=%b exp=%b", {timeout_flag_b, soft_reset_b}, e[9:0]);
    end
    flag_clr_b = 1'b1; exp_q.push_back(32'h0);
    tick(); flag_clr_b = 1'b0;
    e = exp_q.pop_front(); total++;
    if (timeout_flag_b !== e[4:0]) begin bad++; $display("FAIL multi_clr got=%b exp=%b", timeout_flag_b, e[4:0]); end
  endtask

  initial begin
    reset = 1'b1; detect_add = 1'b0; datain = '0; write_enb_reg = 1'b0; flag_clr = 1'b0;
    read_enb = '0; empty = '1; full = '0;
    detect_add_b = 1'b0; datain_b = '0; write_enb_reg_b = 1'b0; flag_clr_b = 1'b0;
    read_enb_b = '0; empty_b = '1; full_b = '0;
    test_reset();
    test_route();
    test_addr_err();
    test_timeout();
    test_restart();
    test_multi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
